// File: rtl/unaligned_mem_mr_if.sv
// Bus bundle for unaligned_mem_mr: one aligned broadcast write port plus NUM_RD
// unaligned read ports, each with request and response valid/ready handshakes.
interface unaligned_mem_mr_if #(
  parameter int unsigned WIDTH_BYTES     = 8,
  parameter int unsigned SIZE_BYTES_LOG2 = 15,
  parameter int unsigned NUM_RD          = 2
);
  localparam int unsigned DW = WIDTH_BYTES * 8;
  localparam int unsigned AW = SIZE_BYTES_LOG2;

  logic                   wr_valid;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  logic [NUM_RD-1:0]      rd_req_valid;
  logic [NUM_RD-1:0]      rd_req_ready;
  logic [NUM_RD*AW-1:0]   rd_req_addr;
  logic [NUM_RD-1:0]      rd_resp_valid;
  logic [NUM_RD-1:0]      rd_resp_ready;
  logic [NUM_RD*DW-1:0]   rd_resp_data;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_req_valid, rd_req_addr, rd_resp_ready,
    input  rd_req_ready, rd_resp_valid, rd_resp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_req_valid, rd_req_addr, rd_resp_ready,
    output rd_req_ready, rd_resp_valid, rd_resp_data
  );
endinterface

// File: rtl/unaligned_mem_mr.sv
// Multi-read-port unaligned line memory: replicated lo/hi bank pairs per read port with a
// credit-gated response FIFO. Define UNALIGNED_MEM_WRITE_FORWARD_EN for write-first reads.
module unaligned_mem_mr #(
  parameter int unsigned WIDTH_BYTES     = 8,
  parameter int unsigned SIZE_BYTES_LOG2 = 15,
  parameter int unsigned NUM_RD          = 2,
  parameter int unsigned RESP_DEPTH      = 4
) (
  input logic              clk,
  input logic              rst,
  unaligned_mem_mr_if.slave bus
);
  localparam int unsigned DW         = WIDTH_BYTES * 8;
  localparam int unsigned AW         = SIZE_BYTES_LOG2;
  localparam int unsigned OFF_W      = $clog2(WIDTH_BYTES);
  localparam int unsigned LINE_W     = AW - OFF_W;
  localparam int unsigned BASE_W     = LINE_W - 1;
  localparam int unsigned BANK_WORDS = 1 << BASE_W;
  localparam int unsigned CNT_W      = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PTR_W      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  // Circular pointer advance for a FIFO whose depth need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  logic [LINE_W-1:0] wr_line;
  logic [BASE_W-1:0] wr_base;
  logic              wr_sel;
  logic [OFF_W-1:0]  unused_wr_offset;

  assign wr_line          = bus.wr_addr[AW-1:OFF_W];
  assign wr_base          = wr_line[LINE_W-1:1];
  assign wr_sel           = wr_line[0];
  assign unused_wr_offset = bus.wr_addr[OFF_W-1:0];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [AW-1:0]     req_addr;
    logic [BASE_W-1:0] req_base;
    logic [BASE_W-1:0] lo_addr;
    logic              req_sel;
    logic [OFF_W-1:0]  req_shift;
    logic              req_ready;
    logic              accept;
    logic              resp_valid;
    logic              push;
    logic              pop;

    logic [DW-1:0]     lo_mem [BANK_WORDS];
    logic [DW-1:0]     hi_mem [BANK_WORDS];
    logic [DW-1:0]     lo_rd_q;
    logic [DW-1:0]     hi_rd_q;
    logic              s1_valid_q;
    logic              s1_sel_q;
    logic [OFF_W-1:0]  s1_shift_q;

    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]     fifo_mem [RESP_DEPTH];

    logic [DW-1:0]     lo_word;
    logic [DW-1:0]     hi_word;
    logic [2*DW-1:0]   cat;
    logic [DW-1:0]     shifted;

    assign req_addr  = bus.rd_req_addr[p*AW +: AW];
    assign req_base  = req_addr[AW-1:OFF_W+1];
    assign req_sel   = req_addr[OFF_W];
    assign req_shift = req_addr[OFF_W-1:0];
    assign lo_addr   = req_base + BASE_W'(req_sel);

    // Credit is registered state only; rst masks it so nothing is taken during reset
    assign req_ready  = !rst && (outstanding_q < CNT_W'(RESP_DEPTH));
    assign accept     = bus.rd_req_valid[p] && req_ready;
    assign resp_valid = (fifo_cnt_q != '0);
    assign pop        = resp_valid && bus.rd_resp_ready[p];
    assign push       = s1_valid_q;

    assign bus.rd_req_ready[p]           = req_ready;
    assign bus.rd_resp_valid[p]          = resp_valid;
    assign bus.rd_resp_data[p*DW +: DW]  = fifo_mem[rd_ptr_q];

    // Bank pair replica: broadcast write, read-first registered read on accept
    always_ff @(posedge clk) begin
      if (bus.wr_valid) begin
        if (!wr_sel) lo_mem[wr_base] <= bus.wr_data;
        else         hi_mem[wr_base] <= bus.wr_data;
      end
      if (accept) begin
        lo_rd_q    <= lo_mem[lo_addr];
        hi_rd_q    <= hi_mem[req_base];
        s1_sel_q   <= req_sel;
        s1_shift_q <= req_shift;
      end
    end

`ifdef UNALIGNED_MEM_WRITE_FORWARD_EN
    logic              fwd_valid_q;
    logic [LINE_W-1:0] fwd_line_q;
    logic [DW-1:0]     fwd_data_q;
    logic [BASE_W-1:0] s1_lo_addr_q;
    logic [BASE_W-1:0] s1_hi_addr_q;

    always_ff @(posedge clk) begin
      if (accept) begin
        fwd_valid_q  <= bus.wr_valid;
        fwd_line_q   <= wr_line;
        fwd_data_q   <= bus.wr_data;
        s1_lo_addr_q <= lo_addr;
        s1_hi_addr_q <= req_base;
      end
    end

    // Patch whichever bank word the accept-cycle write landed on
    always_comb begin
      lo_word = lo_rd_q;
      hi_word = hi_rd_q;
      if (fwd_valid_q && (fwd_line_q == {s1_lo_addr_q, 1'b0})) lo_word = fwd_data_q;
      if (fwd_valid_q && (fwd_line_q == {s1_hi_addr_q, 1'b1})) hi_word = fwd_data_q;
    end
`else
    assign lo_word = lo_rd_q;
    assign hi_word = hi_rd_q;
`endif

    // Order the two lines by address, then drop the leading bytes
    always_comb begin
      cat     = s1_sel_q ? {lo_word, hi_word} : {hi_word, lo_word};
      shifted = DW'(cat >> {s1_shift_q, 3'b000});
    end

    always_comb begin
      outstanding_d = outstanding_q;
      fifo_cnt_d    = fifo_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      if (accept && !pop)      outstanding_d = outstanding_q + CNT_W'(1);
      else if (!accept && pop) outstanding_d = outstanding_q - CNT_W'(1);
      if (push && !pop)        fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      else if (!push && pop)   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q    <= 1'b0;
        outstanding_q <= '0;
        fifo_cnt_q    <= '0;
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
      end else begin
        s1_valid_q    <= accept;
        outstanding_q <= outstanding_d;
        fifo_cnt_q    <= fifo_cnt_d;
        wr_ptr_q      <= wr_ptr_d;
        rd_ptr_q      <= rd_ptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= shifted;
    end
  end

endmodule

// File: tb/tb_unaligned_mem_mr.sv
// Randomized bench for unaligned_mem_mr against a flat byte-array memory model with
// per-port expected-response queues; honours UNALIGNED_MEM_WRITE_FORWARD_EN.
module tb_unaligned_mem_mr;
  localparam int unsigned WB        = 8;
  localparam int unsigned AW        = 15;
  localparam int unsigned NR        = 2;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned DW        = WB * 8;
  localparam int unsigned LINES     = 1 << (AW - 3);
  localparam int unsigned MEM_BYTES = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unaligned_mem_mr_if #(.WIDTH_BYTES(WB), .SIZE_BYTES_LOG2(AW), .NUM_RD(NR)) bus ();

  unaligned_mem_mr #(
    .WIDTH_BYTES(WB), .SIZE_BYTES_LOG2(AW), .NUM_RD(NR), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            acc_cyc;
  } exp_t;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  exp_t          exp_q [NR][$];
  int            out_m [NR];
  logic          hold_q [NR];
  logic [DW-1:0] hold_data [NR];
  logic [7:0]    mem_m [MEM_BYTES];

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference read: WB consecutive bytes from a flat memory, wrapping at the top
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < WB; k++) r[k*8 +: 8] = mem_m[(int'(a) + k) % MEM_BYTES];
    return r;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int base;
    base = (int'(a) / WB) * WB;
    for (int k = 0; k < WB; k++) mem_m[base + k] = d[k*8 +: 8];
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: observes every handshake mid-cycle, before the edge that commits it
  always @(negedge clk) begin : mon
    logic [NR-1:0] acc;
    logic          ev;
    logic          rv;
    logic [DW-1:0] rd;
    exp_t          e;
    acc = '0;
    if (rst) begin
      for (int p = 0; p < NR; p++) begin
        check_val("ready_in_rst", DW'(bus.rd_req_ready[p]), '0);
        exp_q[p].delete();
        out_m[p]  = 0;
        hold_q[p] = 1'b0;
      end
      if (bus.wr_valid) model_write(bus.wr_addr, bus.wr_data);
    end else begin
      for (int p = 0; p < NR; p++) begin
        rv = bus.rd_resp_valid[p];
        rd = bus.rd_resp_data[p*DW +: DW];
        ev = (exp_q[p].size() != 0) && (exp_q[p][0].acc_cyc + 2 <= cyc);
        check_val("req_ready", DW'(bus.rd_req_ready[p]), DW'(out_m[p] < DEPTH));
        check_val("resp_valid", DW'(rv), DW'(ev));
        if (hold_q[p] && rv) check_val("resp_stable", rd, hold_data[p]);
        if (rv && bus.rd_resp_ready[p] && exp_q[p].size() != 0) begin
          check_val("resp_data", rd, exp_q[p][0].data);
          void'(exp_q[p].pop_front());
          out_m[p]--;
        end
        hold_q[p]    = rv && !bus.rd_resp_ready[p];
        hold_data[p] = rd;
        acc[p]       = bus.rd_req_valid[p] && bus.rd_req_ready[p];
      end
`ifdef UNALIGNED_MEM_WRITE_FORWARD_EN
      if (bus.wr_valid) model_write(bus.wr_addr, bus.wr_data);
`endif
      for (int p = 0; p < NR; p++) begin
        if (acc[p]) begin
          e.data    = model_read(bus.rd_req_addr[p*AW +: AW]);
          e.acc_cyc = cyc;
          exp_q[p].push_back(e);
          out_m[p]++;
        end
      end
`ifndef UNALIGNED_MEM_WRITE_FORWARD_EN
      if (bus.wr_valid) model_write(bus.wr_addr, bus.wr_data);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_line(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain();
    bus.rd_req_valid  = '0;
    bus.rd_resp_ready = '1;
    for (int i = 0; i < 40 && (exp_q[0].size() + exp_q[1].size()) != 0; i++) step();
    check_val("drain", DW'(exp_q[0].size() + exp_q[1].size()), '0);
    step();
  endtask

  task automatic rd_one(input int p, input logic [AW-1:0] a, output logic [DW-1:0] d);
    int n;
    bus.rd_req_addr[p*AW +: AW] = a;
    bus.rd_req_valid[p]  = 1'b1;
    bus.rd_resp_ready[p] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.rd_req_ready[p] && n < 50) begin @(negedge clk); n++; end
    step();
    bus.rd_req_valid[p] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.rd_resp_valid[p] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check_val("rd_timeout", 1, 0);
    d = bus.rd_resp_data[p*DW +: DW];
    step();
  endtask

  function automatic logic [AW-1:0] rand_addr(input int mode);
    case (mode)
      0:       return AW'($urandom_range(0, 'h7F));
      1:       return AW'($urandom_range('h7F80, 'h7FFF));
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [DW-1:0] d;
    logic [AW-1:0] bp_addr [6];
    int            idx;
    int            n;
    int            ready_low;
    int            pops [NR];
    logic          took;
    int            mode;

    bus.wr_valid      = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_data       = '0;
    bus.rd_req_valid  = '0;
    bus.rd_req_addr   = '0;
    bus.rd_resp_ready = '1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    for (int l = 0; l < LINES; l++) wr_line(AW'(l * WB), {$urandom, $urandom});

    // Basic unaligned and aligned reads
    wr_line(15'h0000, 64'h0706050403020100);
    wr_line(15'h0008, 64'h0F0E0D0C0B0A0908);
    rd_one(0, 15'h0003, d); check_val("t1_addr3_p0", d, 64'h0A09080706050403);
    rd_one(0, 15'h0000, d); check_val("t1_addr0", d, 64'h0706050403020100);
    rd_one(0, 15'h0008, d); check_val("t1_addr8", d, 64'h0F0E0D0C0B0A0908);
    rd_one(1, 15'h0003, d); check_val("t1_addr3_p1", d, 64'h0A09080706050403);

    // Top-line wrap into line 0
    wr_line(15'h7FF8, 64'hFFFEFDFCFBFAF9F8);
    rd_one(0, 15'h7FFD, d); check_val("t2_wrap_p0", d, 64'h0403020100FFFEFD);
    rd_one(1, 15'h7FFD, d); check_val("t2_wrap_p1", d, 64'h0403020100FFFEFD);

    // Backpressure on port 1
    drain();
    for (int i = 0; i < 6; i++) bp_addr[i] = AW'($urandom);
    bus.rd_resp_ready[1] = 1'b0;
    bus.rd_req_addr[AW +: AW] = bp_addr[0];
    bus.rd_req_valid[1] = 1'b1;
    idx = 0;
    for (int i = 0; i < 60 && idx < 6; i++) begin
      @(negedge clk);
      if (i == 12) begin
        check_val("t3_accepted_stalled", DW'(idx), DW'(4));
        check_val("t3_ready_low", DW'(bus.rd_req_ready[1]), '0);
      end
      took = bus.rd_req_valid[1] && bus.rd_req_ready[1];
      step();
      if (i == 12) bus.rd_resp_ready[1] = 1'b1;
      if (took) begin
        idx++;
        if (idx < 6) bus.rd_req_addr[AW +: AW] = bp_addr[idx];
        else         bus.rd_req_valid[1] = 1'b0;
      end
    end
    check_val("t3_all_accepted", DW'(idx), DW'(6));
    drain();

    // Full-rate streaming on both ports
    bus.rd_req_addr  = {15'd5, 15'd5};
    bus.rd_req_valid = '1;
    ready_low = 0;
    pops[0] = 0;
    pops[1] = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
        if (i < 16 && !bus.rd_req_ready[p]) ready_low++;
        if (bus.rd_resp_valid[p]) pops[p]++;
      end
      step();
      if (i == 15) bus.rd_req_valid = '0;
    end
    check_val("t4_ready_low", DW'(ready_low), '0);
    check_val("t4_pops_p0", DW'(pops[0]), DW'(16));
    check_val("t4_pops_p1", DW'(pops[1]), DW'(16));
    drain();

    // Same-cycle write and read of line 0
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 15'h0000;
    bus.wr_data  = 64'h1111111111111111;
    bus.rd_req_addr[0 +: AW] = 15'h0002;
    bus.rd_req_valid[0] = 1'b1;
    @(negedge clk);
    check_val("t5_ready", DW'(bus.rd_req_ready[0]), 1);
    step();
    bus.wr_valid = 1'b0;
    bus.rd_req_valid[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.rd_resp_valid[0] && n < 50) begin @(negedge clk); n++; end
`ifdef UNALIGNED_MEM_WRITE_FORWARD_EN
    check_val("t5_hazard", bus.rd_resp_data[0 +: DW], 64'h0908111111111111);
`else
    check_val("t5_hazard", bus.rd_resp_data[0 +: DW], 64'h0908070605040302);
`endif
    step();
    drain();

    // Reset with responses in flight
    wr_line(15'h0000, 64'h0706050403020100);
    wr_line(15'h0008, 64'h0F0E0D0C0B0A0908);
    bus.rd_resp_ready[0] = 1'b0;
    bus.rd_req_valid[0]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rd_req_addr[0 +: AW] = AW'(i * 8);
      step();
    end
    bus.rd_req_addr[0 +: AW] = 15'h0003;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_val("t6_ready_after_rst", DW'(bus.rd_req_ready[0]), 1);
    check_val("t6_no_valid", DW'(bus.rd_resp_valid[0]), '0);
    step();
    bus.rd_req_valid[0]  = 1'b0;
    bus.rd_resp_ready[0] = 1'b1;
    @(negedge clk);
    check_val("t6_valid_t1", DW'(bus.rd_resp_valid[0]), '0);
    @(negedge clk);
    check_val("t6_valid_t2", DW'(bus.rd_resp_valid[0]), 1);
    check_val("t6_data", bus.rd_resp_data[0 +: DW], 64'h0A09080706050403);
    step();
    drain();

    // Randomized traffic with hazards, backpressure and occasional reset
    for (int i = 0; i < 2500; i++) begin
      rst  = ($urandom_range(0, 499) == 0);
      mode = int'($urandom_range(0, 2));
      bus.wr_valid = ($urandom_range(0, 9) < 3);
      bus.wr_addr  = rand_addr(mode);
      bus.wr_data  = {$urandom, $urandom};
      for (int p = 0; p < NR; p++) begin
        bus.rd_req_valid[p]  = ($urandom_range(0, 9) < 6);
        bus.rd_req_addr[p*AW +: AW] = rand_addr(mode);
        bus.rd_resp_ready[p] = ($urandom_range(0, 9) < 7);
      end
      step();
    end
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unaligned_mem_mr.md
Name: unaligned_mem_mr

Overview:
- Multi-read-port successor to the two-bank unaligned memory.
- One aligned write port broadcasts into NUM_RD replicated lo/hi bank pairs, one pair per read port.
- Each read port accepts one unaligned WIDTH_BYTES read per cycle through a valid/ready handshake, with a per-port response FIFO so consumers may backpressure.
- Sits between the input-window writer and multiple parallel match/compare engines.

Parameters:
- WIDTH_BYTES, 8, line width in bytes; power of two, >=2.
- SIZE_BYTES_LOG2, 15, log2 of memory size in bytes.
- NUM_RD, 2, number of independent read ports; >=1.
- RESP_DEPTH, 4, per-port response FIFO entries; >=2; full throughput needs >=3.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  write strobe; no backpressure.
- wr_addr  in  SIZE_BYTES_LOG2  byte address; low log2(WIDTH_BYTES) bits ignored.
- wr_data  in  WIDTH_BYTES*8  line data; byte 0 at bits [7:0].
- rd_req_valid  in  NUM_RD  per-port request valid.
- rd_req_ready  out  NUM_RD  per-port request ready.
- rd_req_addr  in  NUM_RD*SIZE_BYTES_LOG2  per-port unaligned byte address; port i occupies slice i.
- rd_resp_valid  out  NUM_RD  per-port response valid.
- rd_resp_ready  in  NUM_RD  per-port response ready.
- rd_resp_data  out  NUM_RD*WIDTH_BYTES*8  per-port data; byte at the requested address in bits [7:0].

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high, on port rst.
- Address split:
  - {base, sel, shift} = addr.
  - Even lines live in bank lo, odd lines in bank hi.
  - Read: lo address = base+sel, hi address = base. Data is concatenated {hi,lo} (sel=0) or {lo,hi} (sel=1), then shifted right by shift*8 bits.
- Wrap-around: base+sel wraps modulo 2^(SIZE_BYTES_LOG2-log2(WIDTH_BYTES)-1). A read in the top line returns the upper bytes followed by bytes from address 0.
- Write:
  - Line sel bit selects the bank.
  - The same write goes to every port's bank pair in the same cycle.
  - Memory contents are not reset.
- Handshake:
  - A request is accepted when rd_req_valid[i] & rd_req_ready[i].
  - Accepted requests are returned in order.
  - Response is fixed-latency: accepted at T, SRAM output at T+1, shifted data registered into the FIFO at end of T+1, rd_resp_valid high at T+2 at the earliest.
  - A response pops on rd_resp_valid & rd_resp_ready.
  - rd_resp_data stays stable while valid and not popped.
- Credit:
  - outstanding[i] = accepted-not-yet-popped count, range 0..RESP_DEPTH.
  - It is incremented on accept and decremented on pop; a simultaneous accept and pop leaves it unchanged.
  - rd_req_ready[i] = (outstanding[i] < RESP_DEPTH). No pop lookahead is used, so ready is registered-state-only and contains no combinational path from rd_resp_ready.
  - The FIFO never overflows.
- Ports are fully independent. Identical addresses on all ports in the same cycle are legal.
- Read/write hazard: a write at T and a read accepted at T touching the same line give read-first behaviour (old data) unless the optional feature is enabled. A write at T visible to a read accepted at T+1 or later.
- Reset:
  - rd_resp_valid = 0 and outstanding = 0.
  - rd_req_ready = 0 while rst is high, 1 in the first cycle after release.
  - In-flight reads and FIFO contents are discarded, including when rst is asserted mid-operation.
  - A request presented during rst is not accepted.
- rd_resp_data is don't-care while rd_resp_valid = 0.

Optional Feature:
- Macro: UNALIGNED_MEM_WRITE_FORWARD_EN.
- Defined:
  - Each port registers the accept-cycle write (valid, line address, data).
  - At T+1, the bank word whose line address equals the registered write line is replaced by the registered write data before concatenation.
  - A same-cycle write is therefore observed (write-first). Cost: one line register plus one comparator per bank per port.
- Undefined: read-first as specified above; no forwarding logic.

Test Plan:
1. Write line 0 = 0x0706050403020100 and line 8 = 0x0F0E0D0C0B0A0908; port 0 reads addr 3 at T -> rd_resp_valid[0] at T+2 with 0x0A09080706050403. Reads of addr 0 and addr 8 return the lines unchanged.
2. Wrap: write addr 0x7FF8 = 0xFFFEFDFCFBFAF9F8 and line 0 as in test 1; read 0x7FFD -> 0x0403020100FFFEFD.
3. Backpressure, RESP_DEPTH=4: hold rd_resp_ready[1] = 0 and stream 6 reads on port 1 -> exactly 4 accepted and ready drops. Raise resp_ready -> 4 responses in order, then ready returns and the remaining 2 complete in order.
4. Both ports read addr 5 every cycle for 16 cycles with resp_ready = 1 -> 1 response per cycle per port, identical data, ready never low.
5. Same-cycle write 0x1111111111111111 to line 0 and read addr 2 with old line 0 = test-1 data. Without the macro -> 0x0908070605040302. With UNALIGNED_MEM_WRITE_FORWARD_EN -> 0x0908111111111111.
6. Accept 3 reads, assert rst for 1 cycle before any pop -> no rd_resp_valid after reset; ready = 1 the cycle after release; a new read then returns correct data at T+2.
